// File: rtl/mux_sel_rr_arbiter_if.sv
// Request/grant bundle between a requester block and the mux select arbiter.
interface mux_sel_rr_arbiter_if #(
    parameter int unsigned DWELL_W = 4
);
    logic               i_en;
    logic [3:0]         i_req;
    logic [DWELL_W-1:0] i_dwell;
    logic [1:0]         o_sel_code;
    logic               o_en;
    logic [3:0]         o_grant;
    logic               o_busy;

    modport master (
        output i_en, i_req, i_dwell,
        input  o_sel_code, o_en, o_grant, o_busy
    );

    modport slave (
        input  i_en, i_req, i_dwell,
        output o_sel_code, o_en, o_grant, o_busy
    );
endinterface

// File: rtl/mux_sel_rr_arbiter.sv
// Round-robin select generator for a 4:1 mux: programmable dwell per grant and
// one disabled cycle between grants so the mux never switches while enabled.
module mux_sel_rr_arbiter #(
    parameter int unsigned DWELL_W = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    mux_sel_rr_arbiter_if.slave   arb
);
    typedef enum logic {ST_IDLE, ST_GRANT} state_t;

    state_t             r_state;
    logic [1:0]         r_ptr;
    logic [DWELL_W-1:0] r_cnt;
    logic [1:0]         r_sel;
    logic               r_en;
    logic [3:0]         r_grant;
    logic               r_busy;

    logic [7:0]         w_req2;
    logic [3:0]         w_rot;
    logic [1:0]         w_off;
    logic [1:0]         w_pick;
    logic [DWELL_W-1:0] w_dwell_ld;
    logic               w_end;

    // Rotate requests so bit 0 is the channel right after the last-served one.
    assign w_req2 = {arb.i_req, arb.i_req};
    assign w_rot  = w_req2[{1'b0, r_ptr} + 3'd1 +: 4];

    always_comb begin
        w_off = 2'd3;
        if (w_rot[0])      w_off = 2'd0;
        else if (w_rot[1]) w_off = 2'd1;
        else if (w_rot[2]) w_off = 2'd2;
    end

    assign w_pick     = r_ptr + 2'd1 + w_off;
    assign w_dwell_ld = (arb.i_dwell == '0) ? DWELL_W'(1) : arb.i_dwell;
    assign w_end      = (r_cnt == DWELL_W'(1)) || !arb.i_req[r_sel] || !arb.i_en;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= 2'd3;
            r_cnt   <= '0;
            r_sel   <= 2'd0;
            r_en    <= 1'b0;
            r_grant <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (arb.i_en && (arb.i_req != '0)) begin
                        r_state <= ST_GRANT;
                        r_sel   <= w_pick;
                        r_grant <= 4'b0001 << w_pick;
                        r_en    <= 1'b1;
                        r_busy  <= 1'b1;
                        r_ptr   <= w_pick;
                        r_cnt   <= w_dwell_ld;
                    end
                end
                ST_GRANT: begin
                    if (w_end) begin
                        r_state <= ST_IDLE;
                        r_en    <= 1'b0;
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - DWELL_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign arb.o_sel_code = r_sel;
    assign arb.o_en       = r_en;
    assign arb.o_grant    = r_grant;
    assign arb.o_busy     = r_busy;
endmodule
